semaforo_multi: RTL and testbench

//  Parametrised N-way traffic-light controller with pedestrian request; successor to the 2-way semaforo.

---
 rtl/semaforo_multi_if.sv | 32 +++
 rtl/semaforo_multi.sv | 195 +++++++++++++++++++
 tb/tb_semaforo_multi.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/semaforo_multi_if.sv
// -----------------------------------------------------------------------------
// semaforo_multi_if
//   Bundles the lamp/button signals of the N-way traffic-light controller.
//   master : board side (drives the button, reads the lamps)
//   slave  : controller side (samples the button, drives the lamps)
//   Signals:
//     bt       pedestrian button level
//     luz      3 bits per approach, way k at luz[3k+2:3k] (001 G, 010 Y, 100 R)
//     ped      pedestrian walk lamp
//     fase     index of the approach owning the current green/yellow/clearance
//     noturno  night (flashing) mode request, only with SEMAFORO_NOTURNO_EN
// -----------------------------------------------------------------------------
interface semaforo_multi_if #(
  parameter int N_VIAS = 2
);
  localparam int FW = $clog2(N_VIAS);

  logic                bt;
  logic [3*N_VIAS-1:0] luz;
  logic                ped;
  logic [FW-1:0]       fase;

`ifdef SEMAFORO_NOTURNO_EN
  logic                noturno;

  modport master (output bt, output noturno, input luz, input ped, input fase);
  modport slave  (input bt, input noturno, output luz, output ped, output fase);
`else
  modport master (output bt, input luz, input ped, input fase);
  modport slave  (input bt, output luz, output ped, output fase);
`endif
endinterface

// File: rtl/semaforo_multi.sv
// -----------------------------------------------------------------------------
// semaforo_multi
//   N-way round-robin traffic-light controller with latched pedestrian request.
//   Each approach gets green, then yellow, then an all-red clearance; a pending
//   pedestrian request inserts an all-red walk phase after the clearance.
//
//   Optional feature macro: SEMAFORO_NOTURNO_EN adds the noturno input and the
//   PISCA (flashing yellow) night state.
//
//   Ports:
//     clk   rising-edge system clock
//     rst   asynchronous reset, active low
//     bus   semaforo_multi_if.slave: bt in, luz/ped/fase out (noturno in when
//           the night feature is built)
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module semaforo_multi #(
  parameter int N_VIAS     = 2,
  parameter int CW         = 8,
  parameter int T_VERDE    = 1,
  parameter int T_AMARELO  = 3,
  parameter int T_VERMELHO = 2,
  parameter int T_PED      = 4
) (
  input  logic             clk,
  input  logic             rst,
  semaforo_multi_if.slave  bus
);

  localparam int FW = $clog2(N_VIAS);
  localparam int LW = 3 * N_VIAS;
  localparam int TMAX = (1 << CW) - 1;

  localparam logic [2:0] LAMP_VERDE    = 3'b001;
  localparam logic [2:0] LAMP_AMARELO  = 3'b010;
  localparam logic [2:0] LAMP_VERMELHO = 3'b100;

  if (N_VIAS < 2 || N_VIAS > 8) begin : g_bad_n_vias
    $error("semaforo_multi: N_VIAS must be 2..8");
  end
  if (T_VERDE < 1 || T_VERDE > TMAX || T_AMARELO < 1 || T_AMARELO > TMAX ||
      T_VERMELHO < 1 || T_VERMELHO > TMAX || T_PED < 1 || T_PED > TMAX) begin : g_bad_t
    $error("semaforo_multi: every T_* must be 1..2^CW-1");
  end

`ifdef SEMAFORO_NOTURNO_EN
  localparam int SW = 3;
`else
  localparam int SW = 2;
`endif

  typedef enum logic [SW-1:0] {
    VERDE,
    AMARELO,
    VERMELHO,
    PEDESTRE
`ifdef SEMAFORO_NOTURNO_EN
    , PISCA
`endif
  } state_t;

  // Terminal count of each timed phase.
  function automatic logic [CW-1:0] last_cnt(input state_t s);
    logic [CW-1:0] v;
    v = '0;
    case (s)
      VERDE:    v = CW'(T_VERDE - 1);
      AMARELO:  v = CW'(T_AMARELO - 1);
      VERMELHO: v = CW'(T_VERMELHO - 1);
      PEDESTRE: v = CW'(T_PED - 1);
      default:  v = '0;
    endcase
    return v;
  endfunction

  // Lamp pattern for a normal (non-flashing) state: only the owning way can
  // show green or yellow, everyone else is red.
  function automatic logic [LW-1:0] lamps(input state_t s, input logic [FW-1:0] f);
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < N_VIAS; k++) begin
      v[3*k +: 3] = LAMP_VERMELHO;
      if (FW'(k) == f) begin
        if (s == VERDE)        v[3*k +: 3] = LAMP_VERDE;
        else if (s == AMARELO) v[3*k +: 3] = LAMP_AMARELO;
      end
    end
    return v;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   fase_q, fase_d;
  logic            req_q, req_d;
  logic [LW-1:0]   luz_q, luz_d;
  logic            ped_q, ped_d;
`ifdef SEMAFORO_NOTURNO_EN
  logic            blink_q, blink_d;
`endif

  logic            phase_end;
  logic [FW-1:0]   fase_nxt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fase_d    = fase_q;
    req_d     = req_q;
`ifdef SEMAFORO_NOTURNO_EN
    blink_d   = blink_q;
`endif
    phase_end = (cnt_q == last_cnt(state_q));
    fase_nxt  = (fase_q == FW'(N_VIAS - 1)) ? '0 : fase_q + 1'b1;

    // Presses during the walk phase are dropped; later overrides clear it on
    // the entry edge and in night mode.
    if (bus.bt && (state_q != PEDESTRE)) req_d = 1'b1;

`ifdef SEMAFORO_NOTURNO_EN
    if (state_q == PISCA) begin
      req_d = 1'b0;
      if (bus.noturno) begin
        blink_d = ~blink_q;
      end else begin
        state_d = VERMELHO;
        cnt_d   = '0;
      end
    end else if (phase_end && bus.noturno) begin
      state_d = PISCA;
      cnt_d   = '0;
      req_d   = 1'b0;
      blink_d = 1'b1;
    end else
`endif
    if (phase_end) begin
      cnt_d = '0;
      case (state_q)
        VERDE:    state_d = AMARELO;
        AMARELO:  state_d = VERMELHO;
        VERMELHO: begin
          if (req_q) begin
            state_d = PEDESTRE;
            req_d   = 1'b0;
          end else begin
            state_d = VERDE;
            fase_d  = fase_nxt;
          end
        end
        PEDESTRE: begin
          state_d = VERDE;
          fase_d  = fase_nxt;
        end
        default: ;
      endcase
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs are decoded from the next state so they register in step with it.
    luz_d = lamps(state_d, fase_d);
`ifdef SEMAFORO_NOTURNO_EN
    if (state_d == PISCA) luz_d = {N_VIAS{blink_d ? LAMP_AMARELO : 3'b000}};
`endif
    ped_d = (state_d == PEDESTRE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= VERDE;
      cnt_q   <= '0;
      fase_q  <= '0;
      req_q   <= 1'b0;
      luz_q   <= lamps(VERDE, '0);
      ped_q   <= 1'b0;
`ifdef SEMAFORO_NOTURNO_EN
      blink_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fase_q  <= fase_d;
      req_q   <= req_d;
      luz_q   <= luz_d;
      ped_q   <= ped_d;
`ifdef SEMAFORO_NOTURNO_EN
      blink_q <= blink_d;
`endif
    end
  end

  assign bus.luz  = luz_q;
  assign bus.ped  = ped_q;
  assign bus.fase = fase_q;

endmodule

// File: tb/tb_semaforo_multi.sv
module tb_semaforo_multi;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bt  = 1'b0;
  logic noturno_tb = 1'b0;

  always #5 clk = ~clk;

  semaforo_multi_if #(.N_VIAS(2)) if2 ();
  semaforo_multi_if #(.N_VIAS(4)) if4 ();

  assign if2.bt = bt;
  assign if4.bt = bt;
`ifdef SEMAFORO_NOTURNO_EN
  assign if2.noturno = noturno_tb;
  assign if4.noturno = noturno_tb;
`endif

  semaforo_multi #(.N_VIAS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  semaforo_multi #(.N_VIAS(4), .T_VERDE(2)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance is a phase name plus cycles remaining in it.
  localparam int PG = 0, PY = 1, PR = 2, PP = 3, PB = 4;
  int nv [2] = '{2, 4};
  int tg [2] = '{1, 2};
  int m_ph [2];
  int m_rem [2];
  int m_fase [2];
  bit m_req [2];
  bit m_blink [2];

  function automatic int dur(input int i, input int ph);
    case (ph)
      PG: return tg[i];
      PY: return 3;
      PR: return 2;
      PP: return 4;
      default: return 1;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = PG; m_rem[i] = tg[i]; m_fase[i] = 0; m_req[i] = 0; m_blink[i] = 0;
    end
  endtask

  task automatic m_step(input bit b, input bit nt);
    for (int i = 0; i < 2; i++) begin
      int ph;
      bit nreq;
      ph = m_ph[i];
      nreq = m_req[i];
      if (ph != PP && b) nreq = 1;
      if (ph == PB) begin
        nreq = 0;
        if (!nt) begin m_ph[i] = PR; m_rem[i] = dur(i, PR); end
        else m_blink[i] = ~m_blink[i];
      end else if (m_rem[i] == 1) begin
        if (nt) begin
          m_ph[i] = PB; m_blink[i] = 1; nreq = 0;
        end else begin
          case (ph)
            PG: m_ph[i] = PY;
            PY: m_ph[i] = PR;
            PR: if (m_req[i]) begin m_ph[i] = PP; nreq = 0; end
                else begin m_ph[i] = PG; m_fase[i] = (m_fase[i] + 1) % nv[i]; end
            default: begin m_ph[i] = PG; m_fase[i] = (m_fase[i] + 1) % nv[i]; end
          endcase
        end
        m_rem[i] = dur(i, m_ph[i]);
      end else begin
        m_rem[i] = m_rem[i] - 1;
      end
      m_req[i] = nreq;
    end
  endtask

  function automatic logic [31:0] exp_luz(input int i);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nv[i]; k++) begin
      logic [2:0] c;
      if (m_ph[i] == PB)                   c = m_blink[i] ? 3'b010 : 3'b000;
      else if (k == m_fase[i] && m_ph[i] == PG) c = 3'b001;
      else if (k == m_fase[i] && m_ph[i] == PY) c = 3'b010;
      else                                 c = 3'b100;
      v[3*k +: 3] = c;
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else      m_step(bt, noturno_tb);
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("luz2",  32'(if2.luz),  exp_luz(0));
      check("ped2",  32'(if2.ped),  32'(m_ph[0] == PP));
      check("fase2", 32'(if2.fase), m_fase[0]);
      check("luz4",  32'(if4.luz),  exp_luz(1));
      check("ped4",  32'(if4.ped),  32'(m_ph[1] == PP));
      check("fase4", 32'(if4.fase), m_fase[1]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus and literal pins ----------------
  logic [5:0] tab12 [12] = '{6'b100001, 6'b100010, 6'b100010, 6'b100010, 6'b100100, 6'b100100,
                             6'b001100, 6'b010100, 6'b010100, 6'b010100, 6'b100100, 6'b100100};

  initial begin
    bit found;
    int prev, wraps;
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    check("rst_luz2", 32'(if2.luz), 32'h21);
    check("rst_luz4", 32'(if4.luz), 32'h921);
    check("rst_ped2", 32'(if2.ped), 0);
    check("rst_fase4", 32'(if4.fase), 0);
    rst = 1'b1;

    // 12-cycle period, no pedestrian
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      check("period_luz2", 32'(if2.luz), 32'(tab12[i]));
      check("period_ped2", 32'(if2.ped), 0);
    end

    // one press during way0 green
    @(posedge clk); #2; bt = 1'b1;
    @(posedge clk); #2; bt = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("walk_ped2", 32'(if2.ped), 1);
      check("walk_luz2", 32'(if2.luz), 32'h24);
    end
    @(negedge clk); #1;
    check("after_walk_ped2", 32'(if2.ped), 0);
    check("after_walk_luz2", 32'(if2.luz), 32'h0c);
    check("after_walk_fase2", 32'(if2.fase), 1);

    // request, then bt held through the whole walk phase
    bt = 1'b1;
    @(posedge clk); #2; bt = 1'b0;
    repeat (4) @(posedge clk);
    #2; bt = 1'b1;
    repeat (5) @(posedge clk);
    #2; bt = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      check("no_second_walk", 32'(if2.ped), 0);
    end
    check("straight_green_luz2", 32'(if2.luz), 32'h0c);
    check("straight_green_fase2", 32'(if2.fase), 1);

    // N=4 fase sequence with wrap
    prev = int'(if4.fase);
    wraps = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (int'(if4.fase) != prev) begin
        check("fase4_step", 32'(if4.fase), 32'((prev + 1) % 4));
        if (prev == 3) wraps++;
        prev = int'(if4.fase);
      end
    end
    check("fase4_wrap_seen", 32'(wraps > 0), 1);

    // async reset mid-yellow of way1 with a pending request
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk); #1;
      if (if2.luz == 6'b001100) found = 1'b1;
    end
    check("wait_way1_green", 32'(found), 1);
    bt = 1'b1;
    @(posedge clk); #2; bt = 1'b0;
    check("pre_rst_yellow", 32'(if2.luz), 32'h14);
    #1; rst = 1'b0;
    #1;
    check("async_rst_luz2", 32'(if2.luz), 32'h21);
    check("async_rst_ped2", 32'(if2.ped), 0);
    check("async_rst_fase2", 32'(if2.fase), 0);
    @(posedge clk); #2; rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check("req_lost_ped2", 32'(if2.ped), 0);
    end
    @(negedge clk); #1;
    check("req_lost_green1", 32'(if2.luz), 32'h0c);

`ifdef SEMAFORO_NOTURNO_EN
    // night mode
    @(posedge clk); #2; noturno_tb = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk); #1;
      if (if2.luz == 6'b010010) found = 1'b1;
    end
    check("pisca_entry", 32'(found), 1);
    @(negedge clk); #1;
    check("pisca_off", 32'(if2.luz), 32'h00);
    @(negedge clk); #1;
    check("pisca_on", 32'(if2.luz), 32'h12);
    check("pisca_ped", 32'(if2.ped), 0);
    @(posedge clk); #2; noturno_tb = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("pisca_exit_red_a", 32'(if2.luz), 32'h24);
    @(negedge clk); #1;
    check("pisca_exit_red_b", 32'(if2.luz), 32'h24);
    @(negedge clk); #1;
    check("pisca_exit_green", 32'(if2.luz != 6'b100100), 1);
`endif

    repeat (4) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
